// File: rtl/clint_vec_pkg.sv
// Shared encodings for the vectored core-local interrupt controller:
// FSM states, CSR addresses, mstatus bit positions and mtvec mode codes.
package clint_vec_pkg;

    // One-hot so each state bit can be probed directly by checkers.
    typedef enum logic [6:0] {
        ST_IDLE    = 7'b000_0001,
        ST_MEPC    = 7'b000_0010,
        ST_MSTATUS = 7'b000_0100,
        ST_MCAUSE  = 7'b000_1000,
        ST_ENTER   = 7'b001_0000,
        ST_MRET    = 7'b010_0000,
        ST_RET     = 7'b100_0000
    } state_t;

    localparam logic [11:0] CSR_MEPC_ADDR    = 12'h341;
    localparam logic [11:0] CSR_MSTATUS_ADDR = 12'h300;
    localparam logic [11:0] CSR_MCAUSE_ADDR  = 12'h342;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/clint_vec_if.sv
// Core-side bundle of the interrupt controller: IRQ lines, pipeline context,
// CSR read values in; CSR write strobe, EX redirect, acknowledge and FSM state out.
interface clint_vec_if #(
    parameter int XLEN    = 16,
    parameter int NUM_IRQ = 4
);
    import clint_vec_pkg::*;

    // No valid/ready pair here: int_we and int_assert are single-cycle strobes
    // that the CSR file and EX stage must accept unconditionally in that cycle.
    logic [NUM_IRQ-1:0] irq_i;
    logic [NUM_IRQ-1:0] irq_en_i;
    logic               global_int_en;
    logic [XLEN-1:0]    inst_addr;
    logic               inst_is_mret;
    logic               jump_flag;
    logic [XLEN-1:0]    jump_addr;
    logic [XLEN-1:0]    csr_mtvec;
    logic [XLEN-1:0]    csr_mepc;
    logic [XLEN-1:0]    csr_mstatus;

    logic               hold_flag_int;
    logic               int_we;
    logic [XLEN-1:0]    int_waddr;
    logic [XLEN-1:0]    int_wdata;
    logic               int_assert;
    logic [XLEN-1:0]    int_addr;
    logic [NUM_IRQ-1:0] irq_ack_o;
    state_t             dbg_state;

    modport master (
        output irq_i, irq_en_i, global_int_en, inst_addr, inst_is_mret,
               jump_flag, jump_addr, csr_mtvec, csr_mepc, csr_mstatus,
        input  hold_flag_int, int_we, int_waddr, int_wdata, int_assert,
               int_addr, irq_ack_o, dbg_state
    );

    modport slave (
        input  irq_i, irq_en_i, global_int_en, inst_addr, inst_is_mret,
               jump_flag, jump_addr, csr_mtvec, csr_mepc, csr_mstatus,
        output hold_flag_int, int_we, int_waddr, int_wdata, int_assert,
               int_addr, irq_ack_o, dbg_state
    );

endinterface

// File: rtl/clint_vec_irq_pend.sv
// One interrupt source: two-flop synchroniser followed by either a level
// pass-through or a sticky rising-edge pending bit cleared by acknowledge.
module clint_vec_irq_pend #(
    parameter bit IS_EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    input  logic ack_i,
    output logic pend_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q,   dly_d;
    logic pend_q,  pend_d;

    always_comb begin
        sync1_d = irq_i;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        pend_d  = 1'b0;
        if (IS_EDGE) begin
            pend_d = pend_q;
            if (ack_i) pend_d = 1'b0;
            // A fresh edge arriving in the ack cycle must not be lost.
            if (sync2_q && !dly_q) pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
            pend_q  <= pend_d;
        end
    end

    assign pend_o = IS_EDGE ? pend_q : sync2_q;

endmodule

// File: rtl/clint_vec.sv
// Core-local interrupt controller: fixed-priority arbitration over NUM_IRQ
// sources, CSR save/restore sequence for trap entry and MRET, EX redirect.
module clint_vec
    import clint_vec_pkg::*;
#(
    parameter int                 XLEN          = 16,
    parameter int                 NUM_IRQ       = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK     = NUM_IRQ'(1),
    parameter int                 CAUSE_BASE    = 4,
    parameter logic [11:0]        CSR_MEPC_A    = CSR_MEPC_ADDR,
    parameter logic [11:0]        CSR_MSTATUS_A = CSR_MSTATUS_ADDR,
    parameter logic [11:0]        CSR_MCAUSE_A  = CSR_MCAUSE_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    clint_vec_if.slave  bus
);

    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] pend_en;
    logic [NUM_IRQ-1:0] ack;
    logic [3:0]         sel_id;
    logic               idle;
    logic               take;

    state_t          state_q, state_d;
    logic [3:0]      id_q, id_d;
    logic [XLEN-1:0] epc_q, epc_d;

    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] mtvec_base;
    logic            we;
    logic [XLEN-1:0] waddr;
    logic [XLEN-1:0] wdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_addr;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_pend
        clint_vec_irq_pend #(.IS_EDGE(EDGE_MASK[i])) u_pend (
            .clk    (clk),
            .rst_n  (rst_n),
            .irq_i  (bus.irq_i[i]),
            .ack_i  (ack[i]),
            .pend_o (pend[i])
        );
    end

    assign pend_en = pend & bus.irq_en_i;

    // Scan from the top so the lowest enabled pending index is the last write.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_en[i]) sel_id = 4'(i);
        end
    end

    assign idle       = (state_q == ST_IDLE);
    assign take       = idle && bus.global_int_en && (|pend_en);
    assign cause      = XLEN'(CAUSE_BASE) + XLEN'(id_q);
    assign mtvec_base = {bus.csr_mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        epc_d         = epc_q;
        we            = 1'b0;
        waddr         = '0;
        wdata         = '0;
        redirect      = 1'b0;
        redirect_addr = '0;
        ack           = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.inst_is_mret) begin
                    state_d = ST_MRET;
                end else if (take) begin
                    id_d    = sel_id;
                    epc_d   = bus.jump_flag ? bus.jump_addr : bus.inst_addr;
                    state_d = ST_MEPC;
                end
            end
            ST_MEPC: begin
                we      = 1'b1;
                waddr   = XLEN'(CSR_MEPC_A);
                wdata   = epc_q;
                state_d = ST_MSTATUS;
            end
            ST_MSTATUS: begin
                we                  = 1'b1;
                waddr               = XLEN'(CSR_MSTATUS_A);
                wdata               = bus.csr_mstatus;
                wdata[MSTATUS_MPIE] = bus.csr_mstatus[MSTATUS_MIE];
                wdata[MSTATUS_MIE]  = 1'b0;
                state_d             = ST_MCAUSE;
            end
            ST_MCAUSE: begin
                we              = 1'b1;
                waddr           = XLEN'(CSR_MCAUSE_A);
                wdata           = cause;
                wdata[XLEN-1]   = 1'b1;
                ack             = NUM_IRQ'(1) << id_q;
                state_d         = ST_ENTER;
            end
            ST_ENTER: begin
                redirect = 1'b1;
                // Reserved modes 10/11 fall back to direct.
                if (bus.csr_mtvec[1:0] == MTVEC_VECTORED) begin
                    redirect_addr = mtvec_base + (cause << 2);
                end else begin
                    redirect_addr = mtvec_base;
                end
                state_d = ST_IDLE;
            end
            ST_MRET: begin
                we                  = 1'b1;
                waddr               = XLEN'(CSR_MSTATUS_A);
                wdata               = bus.csr_mstatus;
                wdata[MSTATUS_MIE]  = bus.csr_mstatus[MSTATUS_MPIE];
                wdata[MSTATUS_MPIE] = 1'b1;
                state_d             = ST_RET;
            end
            ST_RET: begin
                redirect      = 1'b1;
                redirect_addr = bus.csr_mepc;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            epc_q   <= epc_d;
        end
    end

    assign bus.hold_flag_int = take || (bus.inst_is_mret && idle) || !idle;
    assign bus.int_we        = we;
    assign bus.int_waddr     = waddr;
    assign bus.int_wdata     = wdata;
    assign bus.int_assert    = redirect;
    assign bus.int_addr      = redirect_addr;
    assign bus.irq_ack_o     = ack;
    assign bus.dbg_state     = state_q;

endmodule
